// File: rtl/fifo_n2w.sv
// fifo_n2w: narrow-in, wide-out FIFO.
// Each push stores one DATA_WIDTH word. Each pop removes two consecutive words
// and presents them as one 2*DATA_WIDTH word. The older word is in the upper half.
//
// Ports:
//   clk     - single clock; all state changes on its rising edge
//   reset   - synchronous, active-high; clears pointers and count
//   wr      - push request for w_data (dropped while full)
//   w_data  - narrow word to push
//   rd      - pop request for one word pair (ignored while fewer than 2 stored)
//   r_data  - head word pair {older, newer}, combinational from storage
//   empty   - fewer than two narrow entries stored
//   full    - all 2**ADDR_WIDTH narrow entries occupied
//   count   - number of narrow entries stored

module fifo_n2w #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [DATA_WIDTH-1:0]     w_data,
    input  logic                      rd,
    output logic [2*DATA_WIDTH-1:0]   r_data,
    output logic                      empty,
    output logic                      full,
    output logic [ADDR_WIDTH:0]       count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] TWO_C   = (ADDR_WIDTH + 1)'(2);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr_odd;
    logic                  push;
    logic                  pop;

    // Flags come from the registered count only, so wr/rd never reach them.
    assign empty = (count < TWO_C);
    assign full  = (count == DEPTH_C);

    assign push = wr && !full;
    assign pop  = rd && !empty;

    // r_ptr is always even, so the second word of the pair is at r_ptr+1 (mod depth).
    assign r_ptr_odd = r_ptr + ADDR_WIDTH'(1);
    assign r_data    = {mem[r_ptr], mem[r_ptr_odd]};

    // Storage is not reset; after a reset the old words simply become unreachable.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[w_ptr] <= w_data;
        end
    end

    // A push and a pop can never touch the same entry: a pop needs at least two
    // stored words and a push needs at least one free slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                w_ptr <= w_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                r_ptr <= r_ptr + ADDR_WIDTH'(2);
            end
            case ({push, pop})
                2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                2'b01:   count <= count - TWO_C;
                2'b11:   count <= count - (ADDR_WIDTH + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_n2w.sv
// tb_fifo_n2w: self-checking bench for fifo_n2w.
// A queue of narrow words is the reference: pushes append when fewer than
// DEPTH words are held, pops remove the two oldest words when at least two
// are held, reset empties it. Directed scenarios come first, then a long
// randomized run with phases that push the FIFO toward full and toward empty.

module tb_fifo_n2w;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr = 1'b0;
    logic [DW-1:0]   w_data = '0;
    logic            rd = 1'b0;
    logic [2*DW-1:0] r_data;
    logic            empty;
    logic            full;
    logic [AW:0]     count;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] model_q[$];

    fifo_n2w #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .w_data (w_data),
        .rd     (rd),
        .r_data (r_data),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every visible output against the reference queue.
    task automatic checkState();
        int n;
        n = model_q.size();
        checkOutput("count", 32'(count), 32'(n));
        checkOutput("empty", 32'(empty), 32'(n < 2));
        checkOutput("full",  32'(full),  32'(n == DEPTH));
        if (n >= 2) begin
            checkOutput("r_data", 32'(r_data), {16'h0, model_q[0], model_q[1]});
        end
    endtask

    // One clock cycle: drive inputs, take the edge, update the reference, check.
    task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d,
                                 input logic rst = 1'b0);
        bit do_push;
        bit do_pop;
        wr     = w;
        rd     = r;
        w_data = d;
        reset  = rst;
        do_push = w && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() >= 2);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
        end else begin
            if (do_pop) begin
                void'(model_q.pop_front());
                void'(model_q.pop_front());
            end
            if (do_push) begin
                model_q.push_back(d);
            end
        end
        #1;
        wr    = 1'b0;
        rd    = 1'b0;
        reset = 1'b0;
        checkState();
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] b;

        // Reset state
        doReset();
        doReset();
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_full",  32'(full),  32'd0);

        // Two pushes then one pop
        applyStimulus(1'b1, 1'b0, 8'hA1);
        checkOutput("one_word_empty", 32'(empty), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'hB2);
        checkOutput("pair_rdata", 32'(r_data), 32'h0000A1B2);
        checkOutput("pair_count", 32'(count), 32'd2);
        checkOutput("pair_empty", 32'(empty), 32'd0);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("pop_empty", 32'(empty), 32'd1);
        checkOutput("pop_count", 32'(count), 32'd0);

        // Odd leftover: pop ignored with a single stored word
        applyStimulus(1'b1, 1'b0, 8'h55);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, '0);
        checkOutput("odd_count", 32'(count), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h66);
        checkOutput("odd_rdata", 32'(r_data), 32'h00005566);
        applyStimulus(1'b0, 1'b1, '0);

        // Fill, overflow drop, drain
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, DW'(i));
        checkOutput("fill_full",  32'(full),  32'd1);
        checkOutput("fill_count", 32'(count), 32'(DEPTH));
        applyStimulus(1'b1, 1'b0, 8'hFF);
        checkOutput("drop_count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH / 2; i++) begin
            checkOutput("drain_pair", 32'(r_data), 32'({8'(2 * i), 8'(2 * i + 1)}));
            applyStimulus(1'b0, 1'b1, '0);
        end
        checkOutput("drain_empty", 32'(empty), 32'd1);

        // Wrap-around
        doReset();
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 6; i++)  applyStimulus(1'b0, 1'b1, '0);
        for (int i = 0; i < 8; i++)  applyStimulus(1'b1, 1'b0, DW'($urandom));
        for (int i = 0; i < 8; i++)  applyStimulus(1'b0, 1'b1, '0);

        // Simultaneous push and pop at count 3
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, DW'(8'h30 + i));
        applyStimulus(1'b1, 1'b1, 8'h33);
        checkOutput("simul_count", 32'(count), 32'd2);
        checkOutput("simul_head",  32'(r_data), 32'h00003233);

        // Simultaneous push and pop at full: push dropped
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, DW'(8'h40 + i));
        applyStimulus(1'b1, 1'b1, 8'hEE);
        checkOutput("full_simul_count", 32'(count), 32'(DEPTH - 2));
        checkOutput("full_simul_head",  32'(r_data), 32'h00004243);

        // Reset mid-stream with wr and rd high
        doReset();
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, DW'($urandom));
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b1);
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_empty", 32'(empty), 32'd1);
        checkOutput("midrst_full",  32'(full),  32'd0);
        applyStimulus(1'b1, 1'b0, 8'hC3);
        applyStimulus(1'b1, 1'b0, 8'h3C);
        checkOutput("midrst_pair", 32'(r_data), 32'h0000C33C);

        // Randomized run with phases biased toward filling or draining
        for (int phase = 0; phase < 20; phase++) begin
            int wp;
            int rp;
            wp = (phase % 2 == 0) ? 80 : 30;
            rp = (phase % 2 == 0) ? 25 : 70;
            for (int c = 0; c < 120; c++) begin
                b = DW'($urandom);
                applyStimulus(($urandom_range(99) < wp), ($urandom_range(99) < rp), b,
                              ($urandom_range(999) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
